// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit active-low seven-segment scan driver
//
// Scans eight common-anode digits. Digits 7..4 show the alarm setting (HH MM),
// digits 3..0 show the current time (HH MM). The time field blinks while the alarm
// rings. A short all-anodes-off window opens each slot to suppress ghosting.
//
// Ports:
//   clk            system clock
//   rstn           synchronous active-low reset
//   *_now          current time digits, BCD
//   *_bud          alarm setting digits, BCD
//   clk_sec_i      1 Hz square wave, drives colon blink and alarm blink
//   bud_state_i    alarm ringing
//   seg            {CG,CF,CE,CD,CC,CB,CA}, active-low, registered
//   dp             decimal point, active-low, registered
//   an             digit anodes, active-low, an[0] is the rightmost digit, registered

module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 1_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic [3:0] hourdec_bud,
  input  logic [3:0] hourone_bud,
  input  logic [3:0] mindec_bud,
  input  logic [3:0] minone_bud,
  input  logic       clk_sec_i,
  input  logic       bud_state_i,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       dig_idx_q, dig_idx_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [3:0]       digit_val;
  logic [6:0]       digit_seg;
  logic             blank_win;
  logic             blink_off;
  int               slot_int;

  // Slot counter and digit index.
  always_comb begin
    slot_cnt_d = slot_cnt_q + CNT_W'(1);
    dig_idx_d  = dig_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 3'd1;
    end
  end

  // Digit source select.
  always_comb begin
    digit_val = 4'd0;
    case (dig_idx_q)
      3'd0: digit_val = minone_now;
      3'd1: digit_val = mindec_now;
      3'd2: digit_val = hourone_now;
      3'd3: digit_val = hourdec_now;
      3'd4: digit_val = minone_bud;
      3'd5: digit_val = mindec_bud;
      3'd6: digit_val = hourone_bud;
      3'd7: digit_val = hourdec_bud;
      default: digit_val = 4'd0;
    endcase
  end

  // BCD to active-low segments; non-decimal codes show a dash.
  always_comb begin
    digit_seg = 7'b0111111;
    case (digit_val)
      4'd0: digit_seg = 7'b1000000;
      4'd1: digit_seg = 7'b1111001;
      4'd2: digit_seg = 7'b0100100;
      4'd3: digit_seg = 7'b0110000;
      4'd4: digit_seg = 7'b0011001;
      4'd5: digit_seg = 7'b0010010;
      4'd6: digit_seg = 7'b0000010;
      4'd7: digit_seg = 7'b1111000;
      4'd8: digit_seg = 7'b0000000;
      4'd9: digit_seg = 7'b0010000;
      default: digit_seg = 7'b0111111;
    endcase
  end

  // Output next-state. Everything keys off the current slot/digit so seg, dp and
  // an all switch on the same edge and a stale pattern never meets a new anode.
  always_comb begin
    // Signed compare keeps BLANK_CYC == 0 well-defined (window never open).
    slot_int  = int'(slot_cnt_q);
    blank_win = (slot_int < BLANK_CYC);
    blink_off = bud_state_i && !clk_sec_i && !dig_idx_q[2];

    an_d  = blank_win ? 8'hFF : ~(8'd1 << dig_idx_q);
    seg_d = digit_seg;
    dp_d  = 1'b1;
    if (dig_idx_q == 3'd2) begin
      dp_d = ~clk_sec_i;
    end else if (dig_idx_q == 3'd6) begin
      dp_d = 1'b0;
    end
    // Blink blanks the pattern but keeps the anode driven.
    if (blink_off) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_cnt_q <= '0;
      dig_idx_q  <= 3'd0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      dig_idx_q  <= dig_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule
